mem_port_arbiter: RTL and testbench

Sequences and shares the multicycle processor's single-port unified memory between two requesters: the processor's fetch/data port (CPU) and a program loader/debug port (LDR). It sits between the datapath's memory interface and the memory array. It serialises accesses through a three-state FSM with round-robin fairness and a loader lock used during program load. It also provides a CPU stall indication for the controller and a saturating contention counter.

---
 rtl/mem_port_arbiter_if.sv | 51 +++++
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester (CPU, loader) and memory-side signals around the memory port arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_done;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_lock;
  logic              ldr_done;
  logic [DATA_W-1:0] ldr_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [CNT_W-1:0]  conflict_cnt;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_done, cpu_rdata, cpu_stall,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
    output ldr_done, ldr_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output conflict_cnt
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_done, cpu_rdata, cpu_stall,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
    input  ldr_done, ldr_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  conflict_cnt
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-port synchronous memory: IDLE/ACCESS/RESP sequencing,
// round-robin on ties, loader lock that blocks new CPU grants, saturating contention counter.
module mem_port_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  mem_port_arbiter_if.slave io_bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic SEL_CPU = 1'b0;
  localparam logic SEL_LDR = 1'b1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_owner;
  logic              r_last_grant;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [CNT_W-1:0]  r_conflict_cnt;

  logic              w_cpu_resp;
  logic              w_ldr_resp;
  logic              w_arb_phase;
  logic              w_cpu_elig;
  logic              w_ldr_elig;
  logic              w_both;
  logic              w_grant;
  logic              w_winner;
  logic              w_win_we;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Eligibility and winner selection; the owner finishing in RESP sits out this round.
  always_comb begin
    w_cpu_resp  = (r_state == ST_RESP) && (r_owner == SEL_CPU);
    w_ldr_resp  = (r_state == ST_RESP) && (r_owner == SEL_LDR);
    w_arb_phase = (r_state == ST_IDLE) || (r_state == ST_RESP);
    w_cpu_elig  = w_arb_phase & io_bus.cpu_req & ~io_bus.ldr_lock & ~w_cpu_resp;
    w_ldr_elig  = w_arb_phase & io_bus.ldr_req & ~w_ldr_resp;
    w_both      = w_cpu_elig & w_ldr_elig;
    w_grant     = w_cpu_elig | w_ldr_elig;
    if (w_both) begin
      w_winner = ~r_last_grant;
    end else if (w_ldr_elig) begin
      w_winner = SEL_LDR;
    end else begin
      w_winner = SEL_CPU;
    end
    if (w_winner == SEL_LDR) begin
      w_win_we    = io_bus.ldr_we;
      w_win_addr  = io_bus.ldr_addr;
      w_win_wdata = io_bus.ldr_wdata;
    end else begin
      w_win_we    = io_bus.cpu_we;
      w_win_addr  = io_bus.cpu_addr;
      w_win_wdata = io_bus.cpu_wdata;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_state_nxt = ST_ACCESS;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (w_grant) begin
          w_state_nxt = ST_ACCESS;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Memory command, ownership and contention counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_owner        <= SEL_CPU;
      r_last_grant   <= SEL_LDR;
      r_mem_en       <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= {ADDR_W{1'b0}};
      r_mem_wdata    <= {DATA_W{1'b0}};
      r_conflict_cnt <= {CNT_W{1'b0}};
    end else if (w_grant) begin
      r_owner      <= w_winner;
      r_last_grant <= w_winner;
      r_mem_en     <= 1'b1;
      r_mem_we     <= w_win_we;
      r_mem_addr   <= w_win_addr;
      r_mem_wdata  <= w_win_wdata;
      if (w_both) begin
        r_conflict_cnt <= sat_inc(r_conflict_cnt);
      end
    end else if (r_state == ST_ACCESS) begin
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
    end
  end

  // Done and read data are a Moore decode of RESP and the owner; memory data passes straight through.
  assign io_bus.cpu_done     = w_cpu_resp;
  assign io_bus.ldr_done     = w_ldr_resp;
  assign io_bus.cpu_rdata    = w_cpu_resp ? io_bus.mem_rdata : {DATA_W{1'b0}};
  assign io_bus.ldr_rdata    = w_ldr_resp ? io_bus.mem_rdata : {DATA_W{1'b0}};
  assign io_bus.cpu_stall    = io_bus.cpu_req & ~w_cpu_resp;
  assign io_bus.mem_en       = r_mem_en;
  assign io_bus.mem_we       = r_mem_we;
  assign io_bus.mem_addr     = r_mem_addr;
  assign io_bus.mem_wdata    = r_mem_wdata;
  assign io_bus.conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-timeline reference model, directed scenarios,
// randomized traffic, and a CNT_W=4 twin that shares all stimulus to exercise saturation.
module tb_mem_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 16;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(16)) bus ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(4))  bus4 ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(4)) dut4 (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus4)
  );

  assign bus4.cpu_req   = bus.cpu_req;
  assign bus4.cpu_we    = bus.cpu_we;
  assign bus4.cpu_addr  = bus.cpu_addr;
  assign bus4.cpu_wdata = bus.cpu_wdata;
  assign bus4.ldr_req   = bus.ldr_req;
  assign bus4.ldr_we    = bus.ldr_we;
  assign bus4.ldr_addr  = bus.ldr_addr;
  assign bus4.ldr_wdata = bus.ldr_wdata;
  assign bus4.ldr_lock  = bus.ldr_lock;
  assign bus4.mem_rdata = bus.mem_rdata;

  always #5 clk = ~clk;

  // Memory array with a one-cycle synchronous read, plus a backdoor for preloading.
  logic [DW-1:0] ram [0:4095];
  logic [DW-1:0] ram_q;
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;

  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            ram_q <= ram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = ram_q;

  // Reference model: grants placed on a timeline (enable one cycle after grant, done two after).
  logic [DW-1:0] ref_mem [0:4095];
  logic [DW-1:0] exp_rd [2];
  txn_t          cpu_q[$];
  txn_t          ldr_q[$];
  txn_t          en_txn;
  int            cyc, cpu_done_at, ldr_done_at, en_at, next_arb, m_last, m_cnt;
  logic          lock_v;
  int            vectors, miscompares;

  logic          obs_cpu_done, obs_ldr_done, obs_en, obs_stall;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_cpu_rdata, obs_wdata;
  logic [15:0]   obs_cnt;
  logic [3:0]    obs_cnt4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic rst_now);
    txn_t ct, lt, wt;
    logic cr, lr, exp_cd, exp_ld, ce, le;
    int   w;
    cr = (cpu_q.size() > 0);
    lr = (ldr_q.size() > 0);
    ct = cr ? cpu_q[0] : '0;
    lt = lr ? ldr_q[0] : '0;
    rst           = rst_now;
    bus.cpu_req   = cr;
    bus.cpu_we    = ct.we;
    bus.cpu_addr  = ct.addr;
    bus.cpu_wdata = ct.wdata;
    bus.ldr_req   = lr;
    bus.ldr_we    = lt.we;
    bus.ldr_addr  = lt.addr;
    bus.ldr_wdata = lt.wdata;
    bus.ldr_lock  = lock_v;
    @(negedge clk);
    exp_cd = (cyc == cpu_done_at);
    exp_ld = (cyc == ldr_done_at);
    obs_cpu_done  = bus.cpu_done;
    obs_ldr_done  = bus.ldr_done;
    obs_en        = bus.mem_en;
    obs_addr      = bus.mem_addr;
    obs_wdata     = bus.mem_wdata;
    obs_cpu_rdata = bus.cpu_rdata;
    obs_stall     = bus.cpu_stall;
    obs_cnt       = bus.conflict_cnt;
    obs_cnt4      = bus4.conflict_cnt;
    chk("cpu_done", bus.cpu_done, exp_cd);
    chk("ldr_done", bus.ldr_done, exp_ld);
    chk("cpu_stall", bus.cpu_stall, cr & ~exp_cd);
    if (exp_cd) begin
      if (!ct.we) chk("cpu_rdata", bus.cpu_rdata, exp_rd[0]);
    end else chk("cpu_rdata_idle", bus.cpu_rdata, 32'd0);
    if (exp_ld) begin
      if (!lt.we) chk("ldr_rdata", bus.ldr_rdata, exp_rd[1]);
    end else chk("ldr_rdata_idle", bus.ldr_rdata, 32'd0);
    chk("mem_en", bus.mem_en, cyc == en_at);
    if (cyc == en_at) begin
      chk("mem_we", bus.mem_we, en_txn.we);
      chk("mem_addr", bus.mem_addr, en_txn.addr);
      chk("mem_wdata", bus.mem_wdata, en_txn.wdata);
    end else chk("mem_we_idle", bus.mem_we, 32'd0);
    chk("conflict_cnt", bus.conflict_cnt, m_cnt);
    chk("conflict_cnt4", bus4.conflict_cnt, (m_cnt > 15) ? 15 : m_cnt);
    if (exp_cd) void'(cpu_q.pop_front());
    if (exp_ld) void'(ldr_q.pop_front());
    if (rst_now) begin
      cpu_done_at = -1; ldr_done_at = -1; en_at = -1;
      next_arb = cyc + 1; m_last = 1; m_cnt = 0;
    end else if (cyc >= next_arb) begin
      ce = cr & ~lock_v & ~exp_cd;
      le = lr & ~exp_ld;
      if (ce | le) begin
        if (ce & le) begin
          w = 1 - m_last;
          m_cnt++;
        end else w = le ? 1 : 0;
        m_last = w;
        wt = (w == 1) ? lt : ct;
        en_txn = wt;
        en_at = cyc + 1;
        if (w == 1) ldr_done_at = cyc + 2;
        else        cpu_done_at = cyc + 2;
        if (wt.we) ref_mem[wt.addr] = wt.wdata;
        else       exp_rd[w] = ref_mem[wt.addr];
        next_arb = cyc + 2;
      end else next_arb = cyc + 1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic txn_t rnd_txn();
    txn_t t;
    t.we    = 1'($urandom_range(1));
    t.addr  = 12'($urandom_range(15));
    t.wdata = 16'($urandom);
    return t;
  endfunction

  initial begin
    int   cpu_at, ldr_at, guard, found;
    logic any_done, all_stall;
    logic [DW-1:0] rd_seen;
    int   order[$];
    vectors = 0; miscompares = 0; lock_v = 1'b0; rst = 1'b1; bd_we = 1'b0;
    bd_addr = '0; bd_data = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ldr_req = 1'b0; bus.ldr_we = 1'b0; bus.ldr_addr = '0; bus.ldr_wdata = '0;
    bus.ldr_lock = 1'b0;
    for (int a = 0; a <= 16; a++) begin
      bd_we = 1'b1; bd_addr = 12'(a); bd_data = (a == 16) ? 16'h1234 : 16'h0000;
      ref_mem[a] = bd_data;
      @(posedge clk); #1;
    end
    bd_we = 1'b0;
    @(posedge clk); #1;
    cyc = 0; cpu_done_at = -1; ldr_done_at = -1; en_at = -1; next_arb = 0; m_last = 1; m_cnt = 0;

    // Reset state, then a single CPU read of 0x010.
    cpu_q.push_back('{1'b0, 12'h010, 16'h0000});
    cycle(1'b1);
    chk("rst_stall", obs_stall, 1);
    chk("rst_mem_addr", obs_addr, 0);
    chk("rst_mem_wdata", obs_wdata, 0);
    chk("rst_cnt", obs_cnt, 0);
    cycle(1'b0);
    cycle(1'b0);
    chk("s1_en", obs_en, 1);
    chk("s1_addr", obs_addr, 12'h010);
    cycle(1'b0);
    chk("s1_done", obs_cpu_done, 1);
    chk("s1_rdata", obs_cpu_rdata, 16'h1234);
    chk("s1_ldr_done", obs_ldr_done, 0);
    cycle(1'b0);

    // Both request from IDLE after reset.
    cycle(1'b1);
    cpu_q.push_back('{1'b0, 12'h010, 16'h0000});
    ldr_q.push_back('{1'b0, 12'h005, 16'h0000});
    cpu_at = -100; ldr_at = -1;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0);
      if (obs_cpu_done) cpu_at = i;
      if (obs_ldr_done) ldr_at = i;
    end
    chk("s2_cpu_first", cpu_at, 2);
    chk("s2_gap", ldr_at - cpu_at, 2);
    chk("s2_cnt", obs_cnt, 1);

    // Ten grants with both requesters holding requests.
    cycle(1'b1);
    for (int i = 0; i < 5; i++) begin
      cpu_q.push_back('{1'b0, 12'(i), 16'h0000});
      ldr_q.push_back('{1'b0, 12'(i + 8), 16'h0000});
    end
    guard = 0;
    while ((cpu_q.size() + ldr_q.size()) > 0 && guard < 40) begin
      cycle(1'b0);
      if (obs_cpu_done) order.push_back(0);
      if (obs_ldr_done) order.push_back(1);
      guard++;
    end
    chk("s3_drain", cpu_q.size() + ldr_q.size(), 0);
    chk("s3_count", order.size(), 10);
    for (int i = 0; i < order.size(); i++) chk("s3_alternate", order[i], i % 2);
    chk("s3_cnt", obs_cnt, 1);

    // Loader lock: LDR writes 0x0AAA to 0x005 while the CPU waits to read it.
    cycle(1'b1);
    lock_v = 1'b1;
    ldr_q.push_back('{1'b1, 12'h005, 16'h0AAA});
    cpu_q.push_back('{1'b0, 12'h005, 16'h0000});
    any_done = 1'b0; all_stall = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0);
      any_done  = any_done | obs_cpu_done;
      all_stall = all_stall & obs_stall;
    end
    chk("s4_no_cpu_done", any_done, 0);
    chk("s4_stall", all_stall, 1);
    lock_v = 1'b0;
    found = 0; rd_seen = '0;
    for (int i = 0; i < 6 && found == 0; i++) begin
      cycle(1'b0);
      if (obs_cpu_done) begin
        found = 1;
        rd_seen = obs_cpu_rdata;
      end
    end
    chk("s4_release", found, 1);
    chk("s4_rdata", rd_seen, 16'h0AAA);

    // Reset during the ACCESS cycle of a CPU read, then the re-issued read.
    cycle(1'b1);
    cpu_q.push_back('{1'b0, 12'h010, 16'h0000});
    cycle(1'b0);
    cycle(1'b1);
    chk("s5_access_en", obs_en, 1);
    cycle(1'b0);
    chk("s5_after_rst_en", obs_en, 0);
    chk("s5_no_done", obs_cpu_done, 0);
    cycle(1'b0);
    chk("s5_reissue_en", obs_en, 1);
    cycle(1'b0);
    chk("s5_reissue_done", obs_cpu_done, 1);
    chk("s5_reissue_rdata", obs_cpu_rdata, 16'h1234);

    // Eighteen contested grants from IDLE: the 4-bit counter must saturate.
    cycle(1'b1);
    for (int r = 0; r < 18; r++) begin
      cpu_q.push_back(rnd_txn());
      ldr_q.push_back(rnd_txn());
      guard = 0;
      while ((cpu_q.size() + ldr_q.size()) > 0 && guard < 20) begin
        cycle(1'b0);
        guard++;
      end
      cycle(1'b0);
    end
    chk("s6_drain", cpu_q.size() + ldr_q.size(), 0);
    chk("s6_cnt16", obs_cnt, 18);
    chk("s6_cnt4_sat", obs_cnt4, 4'hF);

    // Randomized traffic with a toggling loader lock.
    cycle(1'b1);
    for (int i = 0; i < 400; i++) begin
      if (cpu_q.size() == 0 && $urandom_range(2) == 0) cpu_q.push_back(rnd_txn());
      if (ldr_q.size() == 0 && $urandom_range(2) == 0) ldr_q.push_back(rnd_txn());
      if ($urandom_range(15) == 0) lock_v = ~lock_v;
      cycle(1'b0);
    end
    lock_v = 1'b0;
    guard = 0;
    while ((cpu_q.size() + ldr_q.size()) > 0 && guard < 40) begin
      cycle(1'b0);
      guard++;
    end
    chk("s7_drain", cpu_q.size() + ldr_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
